adpll_lock_ctrl: RTL

- Acquisition and lock sequencer for the all-digital PLL.
- Consumes the signed phase-error code from the TDC encoder, one sample per reference period.
- Drives the 4-bit VCO control code: first a 3-step binary-search coarse acquisition, then bang-bang tracking.
- Declares and withdraws lock. Sits between the encoder/loop filter and the VCO code input.

---
 rtl/adpll_lock_ctrl_if.sv | 24 ++
 rtl/adpll_lock_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/adpll_lock_ctrl_if.sv
// Purpose : bundles the sequencer's control, phase-error and VCO-code signals.
// Ports   : enable/restart/err_valid/phase_err flow into the sequencer (slave);
//           vco_code/code_update/locked/state flow out of it.
// Flow    : no backpressure; err_valid is a one-cycle pulse per reference period.
interface adpll_lock_ctrl_if;
  logic              enable;
  logic              restart;
  logic              err_valid;
  logic signed [3:0] phase_err;
  logic        [3:0] vco_code;
  logic              code_update;
  logic              locked;
  logic        [1:0] state;

  modport master (
    output enable, restart, err_valid, phase_err,
    input  vco_code, code_update, locked, state
  );

  modport slave (
    input  enable, restart, err_valid, phase_err,
    output vco_code, code_update, locked, state
  );
endinterface

// File: rtl/adpll_lock_ctrl.sv
// Purpose : ADPLL acquisition/lock sequencer: 3-step binary-search coarse
//           acquisition, then bang-bang tracking with lock declare/withdraw.
// Latency : a decision on err_valid in cycle N is visible on all outputs at N+1.
// Flow    : no backpressure; every err_valid pulse is consumed as one sample.
// Ports   : clk, reset (sync, active-high); pll (slave modport): enable,
//           restart, err_valid, phase_err in; vco_code, code_update, locked,
//           state out (all registered).
module adpll_lock_ctrl #(
  parameter int SETTLE_TICKS = 2,
  parameter int LOCK_CNT     = 8,
  parameter int UNLOCK_CNT   = 4,
  parameter int TOL          = 1
) (
  input logic              clk,
  input logic              reset,
  adpll_lock_ctrl_if.slave pll
);

  localparam int SW = (SETTLE_TICKS > 0) ? $clog2(SETTLE_TICKS + 1) : 1;
  localparam int LW = $clog2(LOCK_CNT + 1);
  localparam int UW = $clog2(UNLOCK_CNT + 1);

  localparam logic [3:0]    CODE_MID  = 4'd8;
  localparam logic [3:0]    CODE_MAX  = 4'd15;
  localparam logic [2:0]    STEP_INIT = 3'd4;
  localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE_TICKS);
  localparam logic [LW-1:0] LOCK_TGT  = LW'(LOCK_CNT);
  localparam logic [UW-1:0] UNLK_TGT  = UW'(UNLOCK_CNT);
  localparam logic signed [4:0] TOL_S = 5'(TOL);

  typedef enum logic [1:0] {
    IDLE_S   = 2'd0,
    COARSE_S = 2'd1,
    TRACK_S  = 2'd2,
    LOCKED_S = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    code_q, code_d;
  logic          upd_q, upd_d;
  logic          locked_q, locked_d;
  logic [2:0]    step_q, step_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic [UW-1:0] unlock_cnt_q, unlock_cnt_d;

  // Error classification. The error is sign-extended to 5 bits so that the
  // band check against -TOL is exact and -8 always falls outside the band.
  logic signed [4:0] err_ext;
  logic              err_pos;
  logic              err_neg;
  logic              err_zero;
  logic              in_tol;
  logic              above_tol;
  logic              below_tol;

  assign err_ext   = {pll.phase_err[3], pll.phase_err};
  assign err_neg   = pll.phase_err[3];
  assign err_zero  = (pll.phase_err == 4'sd0);
  assign err_pos   = !err_neg && !err_zero;
  assign above_tol = (err_ext > TOL_S);
  assign below_tol = (err_ext < -TOL_S);
  assign in_tol    = !above_tol && !below_tol;

  // Coarse step result, computed one bit wider so an out-of-range result
  // (which the 8 +/- 4 +/- 2 +/- 1 search can never produce) is visible.
  logic [4:0] coarse_res;
  always_comb begin
    coarse_res = {1'b0, code_q};
    if (err_pos) begin
      coarse_res = {1'b0, code_q} + {2'b00, step_q};
    end else if (err_neg) begin
      coarse_res = {1'b0, code_q} - {2'b00, step_q};
    end
  end

  // Tracking step: single LSB moves that saturate at the code limits.
  logic [3:0] track_code;
  always_comb begin
    track_code = code_q;
    if (above_tol && code_q != CODE_MAX) begin
      track_code = code_q + 4'd1;
    end else if (below_tol && code_q != 4'd0) begin
      track_code = code_q - 4'd1;
    end
  end

  logic decide;
  assign decide = pll.enable && !pll.restart && (state_q != IDLE_S) &&
                  pll.err_valid && (settle_q == '0);

  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    locked_d     = locked_q;
    step_d       = step_q;
    settle_d     = settle_q;
    lock_cnt_d   = lock_cnt_q;
    unlock_cnt_d = unlock_cnt_q;

    if (!pll.enable) begin
      state_d      = IDLE_S;
      code_d       = CODE_MID;
      locked_d     = 1'b0;
      step_d       = STEP_INIT;
      settle_d     = '0;
      lock_cnt_d   = '0;
      unlock_cnt_d = '0;
    end else if (pll.restart || state_q == IDLE_S) begin
      // Leaving IDLE and an explicit restart share the same COARSE entry.
      state_d      = COARSE_S;
      code_d       = CODE_MID;
      locked_d     = 1'b0;
      step_d       = STEP_INIT;
      settle_d     = SETTLE_LD;
      lock_cnt_d   = '0;
      unlock_cnt_d = '0;
    end else if (pll.err_valid) begin
      if (settle_q != '0) begin
        settle_d = settle_q - 1'b1;
      end else begin
        unique case (state_q)
          COARSE_S: begin
            code_d = coarse_res[3:0];
            step_d = step_q >> 1;
            if (step_q == 3'd1 || err_zero) begin
              state_d      = TRACK_S;
              lock_cnt_d   = '0;
              unlock_cnt_d = '0;
            end
          end
          TRACK_S: begin
            code_d = track_code;
            if (in_tol) begin
              if (lock_cnt_q != LOCK_TGT) begin
                lock_cnt_d = lock_cnt_q + 1'b1;
              end
              if (lock_cnt_q + 1'b1 == LOCK_TGT || lock_cnt_q == LOCK_TGT) begin
                state_d      = LOCKED_S;
                locked_d     = 1'b1;
                unlock_cnt_d = '0;
              end
            end else begin
              lock_cnt_d = '0;
            end
          end
          LOCKED_S: begin
            code_d = track_code;
            if (!in_tol) begin
              if (unlock_cnt_q != UNLK_TGT) begin
                unlock_cnt_d = unlock_cnt_q + 1'b1;
              end
              if (unlock_cnt_q + 1'b1 == UNLK_TGT || unlock_cnt_q == UNLK_TGT) begin
                state_d      = TRACK_S;
                locked_d     = 1'b0;
                lock_cnt_d   = '0;
                unlock_cnt_d = '0;
              end
            end else begin
              unlock_cnt_d = '0;
            end
          end
          default: begin
          end
        endcase
        // Only a real code movement restarts the settling window; a
        // saturated request leaves the code and the window alone.
        if (code_d != code_q) begin
          settle_d = SETTLE_LD;
        end
      end
    end

    upd_d = (code_d != code_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE_S;
      code_q       <= CODE_MID;
      upd_q        <= 1'b0;
      locked_q     <= 1'b0;
      step_q       <= STEP_INIT;
      settle_q     <= '0;
      lock_cnt_q   <= '0;
      unlock_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      upd_q        <= upd_d;
      locked_q     <= locked_d;
      step_q       <= step_d;
      settle_q     <= settle_d;
      lock_cnt_q   <= lock_cnt_d;
      unlock_cnt_q <= unlock_cnt_d;
    end
  end

  assign pll.vco_code    = code_q;
  assign pll.code_update = upd_q;
  assign pll.locked      = locked_q;
  assign pll.state       = state_q;

  // The binary search must stay inside 1..15 and only runs with a live step.
  a_coarse_range: assert property (
    @(posedge clk) disable iff (reset)
      (decide && state_q == COARSE_S) |->
        (step_q != 3'd0 && coarse_res >= 5'd1 && coarse_res <= 5'd15)
  );

endmodule
